// File: rtl/sccb_req_arbiter.sv
// Round-robin arbiter sharing one SCCB master among NUM_REQ requesters, one transaction outstanding.
// Optional WAIT-state abort counter enabled by defining SCCB_ARB_TIMEOUT_EN.
module sccb_req_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ-1:0]     req_rw_i,
    input  logic [NUM_REQ*7-1:0]   req_slv_i,
    input  logic [NUM_REQ*8-1:0]   req_sub_i,
    input  logic [NUM_REQ*8-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    output logic [7:0]             rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   m_cmd_valid_o,
    input  logic                   m_cmd_ready_i,
    output logic                   m_cmd_rw_o,
    output logic [6:0]             m_cmd_slv_o,
    output logic [7:0]             m_cmd_sub_o,
    output logic [7:0]             m_cmd_wdata_o,
    input  logic                   m_done_i,
    input  logic [7:0]             m_rdata_i,
    input  logic                   m_nack_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cfg
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e             state_q;
    logic [IW-1:0]      last_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] ready_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [7:0]         rdata_q;
    logic               err_q;
    logic               cmd_valid_q;
    logic               cmd_rw_q;
    logic [6:0]         cmd_slv_q;
    logic [7:0]         cmd_sub_q;
    logic [7:0]         cmd_wdata_q;

    logic [IW-1:0]      win_idx_d;
    logic               win_found_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic               to_hit;

`ifdef SCCB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] to_cnt_q;
    assign to_hit = (to_cnt_q == CW'(TIMEOUT_CYC));
`else
    assign to_hit = 1'b0;
`endif

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        gnt_d       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found_d && req_valid_i[(int'(last_q) + k) % NUM_REQ]) begin
                win_found_d = 1'b1;
                win_idx_d   = IW'((int'(last_q) + k) % NUM_REQ);
            end
        end
        gnt_d[win_idx_d] = win_found_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IW'(NUM_REQ - 1);
            gnt_q       <= '0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_rw_q    <= 1'b0;
            cmd_slv_q   <= '0;
            cmd_sub_q   <= '0;
            cmd_wdata_q <= '0;
`ifdef SCCB_ARB_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            ready_q     <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        ready_q     <= gnt_d;
                        gnt_q       <= gnt_d;
                        last_q      <= win_idx_d;
                        cmd_rw_q    <= req_rw_i[win_idx_d];
                        cmd_slv_q   <= req_slv_i[win_idx_d*7 +: 7];
                        cmd_sub_q   <= req_sub_i[win_idx_d*8 +: 8];
                        cmd_wdata_q <= req_wdata_i[win_idx_d*8 +: 8];
                        cmd_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_cmd_ready_i) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= WAIT;
`ifdef SCCB_ARB_TIMEOUT_EN
                        to_cnt_q    <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (m_done_i) begin
                        rdata_q     <= cmd_rw_q ? m_rdata_i : 8'h00;
                        err_q       <= m_nack_i;
                        rsp_valid_q <= gnt_q;
                        state_q     <= RESP;
                    end else if (to_hit) begin
                        rdata_q     <= 8'h00;
                        err_q       <= 1'b1;
                        rsp_valid_q <= gnt_q;
                        state_q     <= RESP;
                    end
`ifdef SCCB_ARB_TIMEOUT_EN
                    else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign m_cmd_valid_o = cmd_valid_q;
    assign m_cmd_rw_o    = cmd_rw_q;
    assign m_cmd_slv_o   = cmd_slv_q;
    assign m_cmd_sub_o   = cmd_sub_q;
    assign m_cmd_wdata_o = cmd_wdata_q;

endmodule

// File: tb/tb_sccb_req_arbiter.sv
// Scoreboard bench for sccb_req_arbiter; the timeout scenario runs when SCCB_ARB_TIMEOUT_EN is defined.
module tb_sccb_req_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid_i = '0;
    logic [N-1:0]   req_rw_i = '0;
    logic [N*7-1:0] req_slv_i = '0;
    logic [N*8-1:0] req_sub_i = '0;
    logic [N*8-1:0] req_wdata_i = '0;
    logic [N-1:0]   req_ready_o;
    logic [N-1:0]   rsp_valid_o;
    logic [7:0]     rsp_rdata_o;
    logic           rsp_err_o;
    logic           m_cmd_valid_o;
    logic           m_cmd_ready_i = 1'b0;
    logic           m_cmd_rw_o;
    logic [6:0]     m_cmd_slv_o;
    logic [7:0]     m_cmd_sub_o;
    logic [7:0]     m_cmd_wdata_o;
    logic           m_done_i = 1'b0;
    logic [7:0]     m_rdata_i = '0;
    logic           m_nack_i = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rw;
        logic [6:0] slv;
        logic [7:0] sub;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct {
        logic [N-1:0] vld;
        logic [7:0]   rdata;
        logic         err;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    sccb_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_rw_i(req_rw_i), .req_slv_i(req_slv_i),
        .req_sub_i(req_sub_i), .req_wdata_i(req_wdata_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .m_cmd_valid_o(m_cmd_valid_o), .m_cmd_ready_i(m_cmd_ready_i), .m_cmd_rw_o(m_cmd_rw_o),
        .m_cmd_slv_o(m_cmd_slv_o), .m_cmd_sub_o(m_cmd_sub_o), .m_cmd_wdata_o(m_cmd_wdata_o),
        .m_done_i(m_done_i), .m_rdata_i(m_rdata_i), .m_nack_i(m_nack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int idx, input logic rw, input logic [6:0] slv,
                           input logic [7:0] sub, input logic [7:0] wd);
        req_rw_i[idx]              = rw;
        req_slv_i[idx*7 +: 7]      = slv;
        req_sub_i[idx*8 +: 8]      = sub;
        req_wdata_i[idx*8 +: 8]    = wd;
        req_valid_i[idx]           = 1'b1;
    endtask

    // Expected command and response are derived when the request is posted.
    function automatic void push_exp(input int idx, input logic rw, input logic [6:0] slv,
                                     input logic [7:0] sub, input logic [7:0] wd,
                                     input logic [7:0] rd, input logic nack);
        cmd_t c;
        rsp_t r;
        c.rw = rw; c.slv = slv; c.sub = sub; c.wdata = wd;
        cmd_q.push_back(c);
        r.vld   = N'(1) << idx;
        r.rdata = rw ? rd : 8'h00;
        r.err   = nack;
        rsp_q.push_back(r);
    endfunction

    task automatic wait_grant(output int gidx);
        int n = 0;
        gidx = -1;
        while (req_ready_o == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready_o !== 2'b01 && req_ready_o !== 2'b10) begin
            errors++;
            $display("FAIL grant_onehot got=%b want=01 or 10", req_ready_o);
        end else begin
            gidx = (req_ready_o == 2'b01) ? 0 : 1;
        end
    endtask

    task automatic serve(input logic [7:0] rd, input logic nack, input int dly, input int stall);
        cmd_t ec;
        rsp_t er;
        int n = 0;
        while (m_cmd_valid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (stall) @(negedge clk);
        checks++;
        if (m_cmd_valid_o !== 1'b1 || cmd_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_valid got=%b want=1 (queued=%0d)", m_cmd_valid_o, cmd_q.size());
            return;
        end
        ec = cmd_q.pop_front();
        checks++;
        if ({m_cmd_rw_o, m_cmd_slv_o, m_cmd_sub_o, m_cmd_wdata_o} !== {ec.rw, ec.slv, ec.sub, ec.wdata}) begin
            errors++;
            $display("FAIL cmd_fields got=%b/%h/%h/%h want=%b/%h/%h/%h", m_cmd_rw_o, m_cmd_slv_o,
                     m_cmd_sub_o, m_cmd_wdata_o, ec.rw, ec.slv, ec.sub, ec.wdata);
        end
        m_cmd_ready_i = 1'b1;
        @(negedge clk);
        m_cmd_ready_i = 1'b0;
        checks++;
        if (m_cmd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL cmd_valid_drop got=%b want=0", m_cmd_valid_o);
        end
        repeat (dly) @(negedge clk);
        m_done_i  = 1'b1;
        m_rdata_i = rd;
        m_nack_i  = nack;
        @(negedge clk);
        m_done_i  = 1'b0;
        m_nack_i  = 1'b0;
        m_rdata_i = 8'hEE;
        checks++;
        if (rsp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_queue_empty got=%b want=nothing", rsp_valid_o);
            return;
        end
        er = rsp_q.pop_front();
        if (rsp_valid_o !== er.vld || rsp_rdata_o !== er.rdata || rsp_err_o !== er.err) begin
            errors++;
            $display("FAIL rsp got=%b/%h/%b want=%b/%h/%b", rsp_valid_o, rsp_rdata_o, rsp_err_o,
                     er.vld, er.rdata, er.err);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid_o !== '0) begin
            errors++;
            $display("FAIL rsp_one_cycle got=%b want=00", rsp_valid_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready_o, rsp_valid_o, m_cmd_valid_o, rsp_err_o} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=0", {req_ready_o, rsp_valid_o, m_cmd_valid_o, rsp_err_o});
        end
        checks++;
        if ({rsp_rdata_o, m_cmd_rw_o, m_cmd_slv_o, m_cmd_sub_o, m_cmd_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h want=0", {rsp_rdata_o, m_cmd_rw_o, m_cmd_slv_o, m_cmd_sub_o, m_cmd_wdata_o});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        set_req(0, 1'b0, 7'h21, 8'h11, 8'hFF);
        push_exp(0, 1'b0, 7'h21, 8'h11, 8'hFF, 8'hC3, 1'b0);
        @(negedge clk);
        checks++;
        if (req_ready_o !== 2'b01) begin
            errors++;
            $display("FAIL write_ready_latency got=%b want=01", req_ready_o);
        end
        req_valid_i = '0;
        serve(8'hC3, 1'b0, 2, 2);
    endtask

    task automatic test_read();
        set_req(1, 1'b1, 7'h21, 8'h2A, 8'h00);
        push_exp(1, 1'b1, 7'h21, 8'h2A, 8'h00, 8'h5A, 1'b0);
        @(negedge clk);
        checks++;
        if (req_ready_o !== 2'b10) begin
            errors++;
            $display("FAIL read_ready got=%b want=10", req_ready_o);
        end
        req_valid_i = '0;
        serve(8'h5A, 1'b0, 0, 0);
    endtask

    task automatic test_round_robin();
        int exp_order[4] = '{0, 1, 0, 1};
        int g;
        set_req(0, 1'b0, 7'h10, 8'h01, 8'hA5);
        set_req(1, 1'b1, 7'h30, 8'h02, 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (exp_order[i] == 0) push_exp(0, 1'b0, 7'h10, 8'h01, 8'hA5, 8'h40 + 8'(i), 1'b0);
            else                   push_exp(1, 1'b1, 7'h30, 8'h02, 8'h00, 8'h40 + 8'(i), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            wait_grant(g);
            checks++;
            if (g !== exp_order[i]) begin
                errors++;
                $display("FAIL rr_order[%0d] got=%0d want=%0d", i, g, exp_order[i]);
            end
            if (i == 3) req_valid_i = '0;
            serve(8'h40 + 8'(i), 1'b0, 1, 0);
        end
    endtask

    task automatic test_nack_and_ignore();
        int g;
        set_req(0, 1'b1, 7'h42, 8'h99, 8'h00);
        push_exp(0, 1'b1, 7'h42, 8'h99, 8'h00, 8'h77, 1'b1);
        wait_grant(g);
        checks++;
        if (g !== 0) begin
            errors++;
            $display("FAIL nack_grant got=%0d want=0", g);
        end
        req_valid_i = '0;
        // Stray done during ISSUE plus a requester that gives up before being granted.
        m_done_i = 1'b1;
        m_nack_i = 1'b1;
        req_valid_i[1] = 1'b1;
        @(negedge clk);
        m_done_i = 1'b0;
        m_nack_i = 1'b0;
        req_valid_i[1] = 1'b0;
        checks++;
        if (rsp_valid_o !== '0 || m_cmd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL done_outside_wait got=%b/%b want=00/1", rsp_valid_o, m_cmd_valid_o);
        end
        serve(8'h77, 1'b1, 3, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready_o !== '0) begin
                errors++;
                $display("FAIL dropped_req_granted got=%b want=00", req_ready_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g;
        cmd_t ec;
        set_req(0, 1'b0, 7'h55, 8'h66, 8'h77);
        push_exp(0, 1'b0, 7'h55, 8'h66, 8'h77, 8'h00, 1'b0);
        void'(rsp_q.pop_back());
        wait_grant(g);
        req_valid_i = '0;
        checks++;
        if (g !== 0 || cmd_q.size() == 0) begin
            errors++;
            $display("FAIL rstmid_grant got=%0d want=0", g);
        end else begin
            ec = cmd_q.pop_front();
        end
        m_cmd_ready_i = 1'b1;
        @(negedge clk);
        m_cmd_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready_o, rsp_valid_o, m_cmd_valid_o, rsp_err_o, rsp_rdata_o,
             m_cmd_rw_o, m_cmd_slv_o, m_cmd_sub_o, m_cmd_wdata_o} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got=%b/%b/%h/%h want=0", req_ready_o, rsp_valid_o,
                     m_cmd_slv_o, m_cmd_wdata_o);
        end
        m_done_i = 1'b1;
        @(negedge clk);
        m_done_i = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_o !== '0) begin
                errors++;
                $display("FAIL rstmid_no_rsp got=%b want=00", rsp_valid_o);
            end
        end
        set_req(0, 1'b1, 7'h0A, 8'h0B, 8'h00);
        set_req(1, 1'b1, 7'h1A, 8'h1B, 8'h00);
        push_exp(0, 1'b1, 7'h0A, 8'h0B, 8'h00, 8'h3C, 1'b0);
        wait_grant(g);
        req_valid_i = '0;
        checks++;
        if (g !== 0) begin
            errors++;
            $display("FAIL rstmid_next_grant got=%0d want=0", g);
        end
        serve(8'h3C, 1'b0, 0, 0);
    endtask

`ifdef SCCB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int g;
        rsp_t er;
        set_req(1, 1'b1, 7'h21, 8'h01, 8'h00);
        push_exp(1, 1'b1, 7'h21, 8'h01, 8'h00, 8'h00, 1'b1);
        wait_grant(g);
        req_valid_i = '0;
        void'(cmd_q.pop_front());
        m_cmd_ready_i = 1'b1;
        @(negedge clk);
        m_cmd_ready_i = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_o !== '0) begin
                errors++;
                $display("FAIL timeout_early k=%0d got=%b want=00", k, rsp_valid_o);
            end
        end
        @(negedge clk);
        er = rsp_q.pop_front();
        checks++;
        if (rsp_valid_o !== er.vld || rsp_err_o !== er.err || rsp_rdata_o !== er.rdata) begin
            errors++;
            $display("FAIL timeout_rsp got=%b/%b/%h want=%b/%b/%h", rsp_valid_o, rsp_err_o,
                     rsp_rdata_o, er.vld, er.err, er.rdata);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_nack_and_ignore();
`ifdef SCCB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
